// File: rtl/data_path.sv
// Single-bus 32-bit datapath: register file, HI/LO, Y/Z ALU pair, MDR/MAR/PC/IR.
// All state loads on the falling clock edge; bus and ALU are purely combinational.
module data_path (
  input  logic        clock,
  input  logic        clear,
  input  logic        read,
  input  logic [31:0] Mdatain,
  input  logic [4:0]  opcode,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        Yin,
  input  logic        MDRin,
  input  logic        MARin,
  input  logic        PCin,
  input  logic        IRin,
  input  logic        Zin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        MDRout,
  input  logic        PCout,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        IncPC,
  output logic [31:0] BusMuxOut,
  output logic [31:0] MARdata,
  output logic [31:0] IRdata
);
  localparam int NUM_REGS = 16;

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00011, OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR  = 5'b00110,
    OP_SHR  = 5'b00111, OP_SHRA = 5'b01000, OP_SHL = 5'b01001, OP_ROR = 5'b01010,
    OP_ROL  = 5'b01011, OP_NEG = 5'b01100, OP_NOT = 5'b01101, OP_MUL = 5'b01110,
    OP_DIV  = 5'b01111
  } alu_op_e;

  logic [NUM_REGS-1:0]       r_in, r_out;
  logic [NUM_REGS-1:0][31:0] r_q;
  logic [31:0] hi_q, lo_q, y_q, mdr_q, mar_q, pc_q, ir_q;
  logic [63:0] z_q;
  logic [31:0] mdr_d;
  logic [63:0] z_d;
  logic [31:0] bus;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};

  // Lowest priority first so later assignments win; R0 ends up highest.
  always_comb begin
    bus = '0;
    if (MDRout)   bus = mdr_q;
    if (PCout)    bus = pc_q;
    if (Zlowout)  bus = z_q[31:0];
    if (Zhighout) bus = z_q[63:32];
    if (LOout)    bus = lo_q;
    if (HIout)    bus = hi_q;
    for (int i = NUM_REGS-1; i >= 0; i--)
      if (r_out[i]) bus = r_q[i];
  end

  assign BusMuxOut = bus;
  assign MARdata   = mar_q;
  assign IRdata    = ir_q;

  // ALU: A = Y, B = bus
  logic [4:0]         sh;
  logic signed [63:0] prod;
  logic signed [31:0] quot, rem;
  logic [31:0]        sra, ror, rol;

  assign sh   = bus[4:0];
  assign prod = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
  assign quot = (bus == '0) ? '0 : $signed(y_q) / $signed(bus);
  assign rem  = (bus == '0) ? '0 : $signed(y_q) % $signed(bus);
  assign sra  = $signed(y_q) >>> sh;
  assign ror  = (y_q >> sh) | (y_q << (6'd32 - {1'b0, sh}));
  assign rol  = (y_q << sh) | (y_q >> (6'd32 - {1'b0, sh}));

  always_comb begin
    z_d = '0;
    if (IncPC) z_d = {32'b0, bus + 32'd1};
    else begin
      case (opcode)
        OP_ADD:  z_d = {32'b0, y_q + bus};
        OP_SUB:  z_d = {32'b0, y_q - bus};
        OP_AND:  z_d = {32'b0, y_q & bus};
        OP_OR:   z_d = {32'b0, y_q | bus};
        OP_SHR:  z_d = {32'b0, y_q >> sh};
        OP_SHRA: z_d = {32'b0, sra};
        OP_SHL:  z_d = {32'b0, y_q << sh};
        OP_ROR:  z_d = {32'b0, ror};
        OP_ROL:  z_d = {32'b0, rol};
        OP_NEG:  z_d = {32'b0, 32'd0 - bus};
        OP_NOT:  z_d = {32'b0, ~bus};
        OP_MUL:  z_d = prod;
        OP_DIV:  z_d = {rem, quot};
        default: z_d = '0;
      endcase
    end
  end

  assign mdr_d = read ? Mdatain : bus;

  always_ff @(negedge clock or posedge clear) begin
    if (clear) begin
      r_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      y_q   <= '0;
      z_q   <= '0;
      mdr_q <= '0;
      mar_q <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (r_in[i]) r_q[i] <= bus;
      if (HIin)  hi_q  <= bus;
      if (LOin)  lo_q  <= bus;
      if (Yin)   y_q   <= bus;
      if (Zin)   z_q   <= z_d;
      if (MDRin) mdr_q <= mdr_d;
      if (MARin) mar_q <= bus;
      if (PCin)  pc_q  <= bus;
      if (IRin)  ir_q  <= bus;
    end
  end
endmodule

// File: tb/tb_data_path.sv
// Randomized and directed checks of data_path against a behavioural register/ALU model.
module tb_data_path;
  logic        clock = 1'b0;
  logic        clear, read, inc;
  logic [31:0] Mdatain;
  logic [4:0]  opcode;
  logic [15:0] rin;
  logic [21:0] osel; // 0..15 R, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR
  logic        hiin, loin, yin, mdrin, marin, pcin, irin, zin;
  logic [31:0] BusMuxOut, MARdata, IRdata;

  int n_chk = 0, n_fail = 0;

  logic [31:0] m_r[16];
  logic [31:0] m_hi, m_lo, m_y, m_mdr, m_mar, m_pc, m_ir;
  logic [63:0] m_z;

  always #5 clock = ~clock;

  data_path dut (
    .clock(clock), .clear(clear), .read(read), .Mdatain(Mdatain), .opcode(opcode),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(osel[0]),   .R1out(osel[1]),   .R2out(osel[2]),   .R3out(osel[3]),
    .R4out(osel[4]),   .R5out(osel[5]),   .R6out(osel[6]),   .R7out(osel[7]),
    .R8out(osel[8]),   .R9out(osel[9]),   .R10out(osel[10]), .R11out(osel[11]),
    .R12out(osel[12]), .R13out(osel[13]), .R14out(osel[14]), .R15out(osel[15]),
    .HIin(hiin), .LOin(loin), .Yin(yin), .MDRin(mdrin), .MARin(marin),
    .PCin(pcin), .IRin(irin), .Zin(zin),
    .HIout(osel[16]), .LOout(osel[17]), .Zhighout(osel[18]), .Zlowout(osel[19]),
    .PCout(osel[20]), .MDRout(osel[21]), .IncPC(inc),
    .BusMuxOut(BusMuxOut), .MARdata(MARdata), .IRdata(IRdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] src_val(input int i);
    if (i < 16) return m_r[i];
    case (i)
      16: return m_hi;
      17: return m_lo;
      18: return m_z[63:32];
      19: return m_z[31:0];
      20: return m_pc;
      default: return m_mdr;
    endcase
  endfunction

  // Bus: first asserted select in priority order, else 0.
  function automatic logic [31:0] exp_bus();
    for (int i = 0; i < 22; i++)
      if (osel[i]) return src_val(i);
    return 32'd0;
  endfunction

  function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic pinc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    int sh;
    logic [31:0] r;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % 32);
    r  = a;
    if (pinc) return {32'd0, b + 32'd1};
    case (op)
      5'd3:  return {32'd0, a + b};
      5'd4:  return {32'd0, a - b};
      5'd5:  return {32'd0, a & b};
      5'd6:  return {32'd0, a | b};
      5'd7:  return {32'd0, a >> sh};
      5'd8:  return {32'd0, 32'(sa >>> sh)};
      5'd9:  return {32'd0, a << sh};
      5'd10: begin repeat (sh) r = {r[0], r[31:1]}; return {32'd0, r}; end
      5'd11: begin repeat (sh) r = {r[30:0], r[31]}; return {32'd0, r}; end
      5'd12: return {32'd0, 32'(-sb)};
      5'd13: return {32'd0, ~b};
      5'd14: return 64'(sa * sb);
      5'd15: begin
        if (sb == 0) return 64'd0;
        return {32'(sa % sb), 32'(sa / sb)};
      end
      default: return 64'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    {m_hi, m_lo, m_y, m_mdr, m_mar, m_pc, m_ir} = '0;
    m_z = '0;
  endtask

  task automatic idle();
    read = 0; inc = 0; Mdatain = '0; opcode = '0; rin = '0; osel = '0;
    {hiin, loin, yin, mdrin, marin, pcin, irin, zin} = '0;
  endtask

  // Inputs are set just after a falling edge; one falling edge later the state updates.
  task automatic step();
    logic [31:0] b;
    logic [63:0] alu;
    #1;
    b   = exp_bus();
    alu = alu_ref(opcode, inc, m_y, b);
    chk("bus", {32'd0, BusMuxOut}, {32'd0, b});
    @(negedge clock); #1;
    for (int i = 0; i < 16; i++) if (rin[i]) m_r[i] = b;
    if (hiin)  m_hi  = b;
    if (loin)  m_lo  = b;
    if (yin)   m_y   = b;
    if (zin)   m_z   = alu;
    if (mdrin) m_mdr = read ? Mdatain : b;
    if (marin) m_mar = b;
    if (pcin)  m_pc  = b;
    if (irin)  m_ir  = b;
    chk("mar", {32'd0, MARdata}, {32'd0, m_mar});
    chk("ir",  {32'd0, IRdata},  {32'd0, m_ir});
  endtask

  task automatic readback(input string tag);
    for (int i = 0; i < 22; i++) begin
      osel = '0;
      osel[i] = 1'b1;
      #1 chk(tag, {32'd0, BusMuxOut}, {32'd0, src_val(i)});
    end
    osel = '0;
  endtask

  task automatic bus_is(input string tag, input int sel, input logic [31:0] exp);
    osel = '0;
    osel[sel] = 1'b1;
    #1 chk(tag, {32'd0, BusMuxOut}, {32'd0, exp});
    osel = '0;
  endtask

  // Put a value in MDR from memory, then copy it via the bus into the chosen target.
  task automatic mdr_load(input logic [31:0] v);
    idle(); read = 1; mdrin = 1; Mdatain = v; step(); idle();
  endtask

  localparam logic [4:0] VALID_OPS [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                            5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15};

  initial begin
    idle();
    clear = 1'b1;
    model_reset();
    #3 clear = 1'b0;
    readback("reset");
    @(negedge clock); #1;

    // PC fetch/increment sequence
    idle(); osel[20] = 1; marin = 1; inc = 1; zin = 1; step();
    chk("req34_mar", {32'd0, MARdata}, 64'd0);
    bus_is("req34_zlow", 19, 32'd1);
    idle(); osel[19] = 1; pcin = 1; read = 1; mdrin = 1; Mdatain = 32'h2A2B8000; step();
    bus_is("req34_pc", 20, 32'd1);
    bus_is("req34_mdr", 21, 32'h2A2B8000);
    idle(); osel[21] = 1; irin = 1; step();
    chk("req34_ir", {32'd0, IRdata}, {32'd0, 32'h2A2B8000});

    // MDR from memory into R3, R7 via MDR, then R4 = R3 + R7
    mdr_load(32'h0000F00D); osel[21] = 1; rin[3] = 1; step();
    bus_is("req32_r3", 3, 32'h0000F00D);
    mdr_load(32'h0000ABCD); osel[21] = 1; rin[7] = 1; step();
    idle(); osel[3] = 1; yin = 1; step();
    idle(); osel[7] = 1; opcode = 5'b00011; zin = 1; step();
    idle(); osel[19] = 1; rin[4] = 1; step();
    bus_is("req33_r4", 4, 32'h00019BDA);

    // R3 and R7 driven together: R3 wins
    idle(); osel[3] = 1; osel[7] = 1;
    #1 chk("req37_prio", {32'd0, BusMuxOut}, {32'd0, 32'h0000F00D});

    // mul and div
    mdr_load(32'd2); osel[21] = 1; rin[1] = 1; step();
    mdr_load(32'hFFFFFFFF); osel[21] = 1; yin = 1; step();
    idle(); osel[1] = 1; opcode = 5'b01110; zin = 1; step();
    bus_is("req35_mul_hi", 18, 32'hFFFFFFFF);
    bus_is("req35_mul_lo", 19, 32'hFFFFFFFE);
    mdr_load(32'd7); osel[21] = 1; yin = 1; step();
    idle(); osel[1] = 1; opcode = 5'b01111; zin = 1; step();
    bus_is("req35_div_lo", 19, 32'd3);
    bus_is("req35_div_hi", 18, 32'd1);
    // divide by zero (empty bus) -> 0
    idle(); opcode = 5'b01111; zin = 1; step();
    bus_is("div0_lo", 19, 32'd0);
    // undefined opcode -> 0
    idle(); osel[1] = 1; opcode = 5'b01110; zin = 1; step();
    idle(); osel[1] = 1; opcode = 5'b10000; zin = 1; step();
    bus_is("badop_lo", 19, 32'd0);
    bus_is("badop_hi", 18, 32'd0);

    // Randomized traffic
    for (int it = 0; it < 400; it++) begin
      idle();
      for (int i = 0; i < 22; i++) osel[i] = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < 16; i++) rin[i] = ($urandom_range(0, 3) == 0);
      {hiin, loin, yin, mdrin, marin, pcin, irin, zin} = 8'($urandom & $urandom);
      read    = 1'($urandom);
      Mdatain = $urandom;
      inc     = ($urandom_range(0, 7) == 0);
      opcode  = ($urandom_range(0, 4) == 0) ? 5'($urandom) : VALID_OPS[$urandom_range(0, 12)];
      if (opcode == 5'd15 && m_y == 32'h80000000 && exp_bus() == 32'hFFFFFFFF) opcode = 5'd3;
      step();
      if (it % 40 == 39) begin
        idle();
        readback("rand_rd");
      end
    end

    // Asynchronous clear between edges
    idle();
    @(posedge clock); #1;
    clear = 1'b1;
    model_reset();
    #1 clear = 1'b0;
    #1 chk("req36_bus_idle", {32'd0, BusMuxOut}, 64'd0);
    chk("req36_mar", {32'd0, MARdata}, 64'd0);
    chk("req36_ir", {32'd0, IRdata}, 64'd0);
    readback("req36_rd");

    // Loads blocked while clear is held over a falling edge
    @(negedge clock); #1;
    idle(); read = 1; mdrin = 1; Mdatain = 32'h12345678; marin = 1; rin[5] = 1;
    clear = 1'b1;
    @(negedge clock); #1;
    clear = 1'b0;
    idle();
    bus_is("clr_hold_mdr", 21, 32'd0);
    bus_is("clr_hold_r5", 5, 32'd0);
    chk("clr_hold_mar", {32'd0, MARdata}, 64'd0);
    // first falling edge after release loads normally
    read = 1; mdrin = 1; Mdatain = 32'h12345678; step();
    idle();
    bus_is("post_clr_mdr", 21, 32'h12345678);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
